// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack data port, stalls
// upstream until the access completes, resolves branches, and forwards write-back data into stores.
//
// state | meaning
// IDLE  | no access outstanding; a new aligned access is issued from here
// BUSY  | request held on the data port, waiting for ack or timeout
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int REG_W   = 5,
  parameter int PC_W    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_mem_read,
  input  logic              m_mem_write,
  input  logic              m_branch,
  input  logic [DATA_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_val,
  input  logic [REG_W-1:0]  m_src,
  input  logic              m_alu_zero,
  input  logic [PC_W-1:0]   m_pc_branch,
  input  logic              w_reg_write,
  input  logic [REG_W-1:0]  w_dst,
  input  logic [DATA_W-1:0] w_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] ld_data,
  output logic              stall,
  output logic              pc_src,
  output logic [PC_W-1:0]   pc_branch_o,
  output logic              mem_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             access;
  logic             misaligned;
  logic             issue;
  logic             ack_hit;
  logic             timeout_hit;
  logic [DATA_W-1:0] fwd;

  assign access     = m_mem_read | m_mem_write;
  assign misaligned = access & (m_addr[1:0] != 2'b00);
  assign issue      = (state_q == IDLE) & access & ~misaligned;
  assign ack_hit    = (state_q == BUSY) & dmem_ack;
  // ack takes priority over an expiring timeout in the same cycle
  assign timeout_hit = (state_q == BUSY) & ~dmem_ack & (cnt_q == CNT_LAST);

  // rt may be produced by the instruction currently in write-back; r0 never forwards
  assign fwd = (w_reg_write && (w_dst == m_src) && (m_src != '0)) ? w_data : m_val;

  assign pc_src      = m_branch & m_alu_zero;
  assign pc_branch_o = m_pc_branch;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    ld_data = '0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          stall   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (ack_hit) begin
          ld_data = dmem_we ? '0 : dmem_rdata;
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      cnt_q      <= '0;
      mem_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= m_mem_write;
        dmem_addr  <= m_addr[ADDR_W-1:0];
        dmem_wdata <= fwd;
        cnt_q      <= '0;
      end else if (state_q == BUSY) begin
        if (ack_hit || timeout_hit) begin
          dmem_req <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (timeout_hit || ((state_q == IDLE) && misaligned)) begin
        mem_err <= 1'b1;
      end
    end
  end

endmodule
